piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
- Parallel-in serial-out transmitter; converts WIDTH-bit words into a one-bit-per-clock serial stream.
- Upstream side uses a valid/ready handshake. A one-entry holding buffer allows back-to-back words with no idle gap between serial frames.
- Serial side drives data, valid, first-bit and last-bit markers to a downstream serial receiver or pin.

Parameters:
- WIDTH, 8, word width in bits (min 2).
- LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit WIDTH-1 transmitted first.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- par_in  input  WIDTH  parallel word to transmit.
- par_valid  input  1  par_in holds a valid word.
- par_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_first  output  1  current bit is the first bit of a word.
- ser_last  output  1  current bit is the last bit of a word.
- busy  output  1  shifting in progress or holding buffer occupied.

Behaviour:
- Internal state:
  - shift register sreg[WIDTH]
  - down-counter cnt[$clog2(WIDTH)]
  - holding register hold[WIDTH] with flag hold_v
  - FSM with states IDLE and SHIFT
- Accept: a word transfers on a rising edge where par_valid && par_ready.
- par_ready = !hold_v. It is combinational from registered state only; no combinational path from par_valid.
- Reset (rst=0, async): state=IDLE, sreg=0, cnt=0, hold=0, hold_v=0. Outputs: par_ready=1, ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0.
- IDLE:
  - On accept: sreg<=par_in, cnt<=WIDTH-1, go to SHIFT. hold is untouched.
- SHIFT, cnt!=0:
  - Shift sreg one position toward the output end each cycle: right shift if LSB_FIRST=1, left shift otherwise.
  - cnt<=cnt-1.
  - On accept: hold<=par_in, hold_v<=1.
- SHIFT, cnt==0 (last bit):
  - If hold_v: sreg<=hold, hold_v<=0, cnt<=WIDTH-1, stay in SHIFT. The next word follows with zero gap.
  - Else if accept (par_ready=1 because hold is empty): sreg<=par_in directly (bypass), cnt<=WIDTH-1, stay in SHIFT. hold_v stays 0.
  - Else go to IDLE.
- Serial outputs are registered-state derived, combinational from flops only:
  - ser_valid = (state==SHIFT).
  - ser_out = ser_valid ? (LSB_FIRST ? sreg[0] : sreg[WIDTH-1]) : 0.
  - ser_first = ser_valid && cnt==WIDTH-1.
  - ser_last = ser_valid && cnt==0.
  - busy = ser_valid || hold_v.
- Latency: a word accepted at edge k drives its first bit in the cycle following edge k. The frame occupies exactly WIDTH consecutive cycles with ser_valid=1.
- Throughput: sustained 1 word per WIDTH cycles. par_ready drops for one word-time while hold is full.
- Upstream must hold par_in/par_valid stable until accepted. Words are never dropped or duplicated. par_in is sampled only on accept edges.
- Reset asserted mid-frame aborts the frame immediately and discards any held word. No partial frame resumes after reset release.
- The down-counter wraps only by reload; cnt never decrements below 0.

Test Plan:
- Reset check: rst low mid-frame with hold_v=1 -> next cycle ser_valid=0, ser_out=0, par_ready=1, busy=0; after release, no bits emitted until a new accept.
- Single word, WIDTH=8, LSB_FIRST=1: accept 0xA5 -> ser_out over 8 cycles = 1,0,1,0,0,1,0,1; ser_first on cycle 1 only; ser_last on cycle 8 only; ser_valid=0 on cycle 9.
- MSB-first, LSB_FIRST=0: accept 0xA5 -> ser_out sequence = 1,0,1,0,0,1,0,1 read MSB to LSB; accept 0x80 -> 1 then seven 0s.
- Back-to-back, par_valid held high with words 0x01, 0xFF, 0x3C -> 24 contiguous ser_valid cycles with no gap; par_ready low while hold is full; ser_first pulses at bit cycles 1, 9 and 17.
- Bypass on last bit: hold empty, assert par_valid with 0x5A exactly on the ser_last cycle -> 0x5A frame starts the next cycle with no gap, and hold_v never sets.
- Reference model: a randomised par_valid stream is deserialised LSB-first into 8-bit words -> recovered words equal accepted words in order; count of accepts equals count of ser_last pulses.

Source files
------------

// File: rtl/piso_shift_if.sv
// Upstream valid/ready word bus plus serial-side outputs of the PISO transmitter.
// master = word producer / serial sink, slave = the transmitter.
interface piso_shift_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] par_in;
  logic             par_valid;
  logic             par_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output par_in, par_valid,
    input  par_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  par_in, par_valid,
    output par_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with a one-word holding buffer so that
// consecutive frames stream with no idle cycle between them.
//
// state | meaning
// IDLE  | no frame on the serial side, waiting for a word
// SHIFT | emitting one bit per cycle; cnt = bits remaining after this one
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         rst,
  piso_shift_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_v_q, hold_v_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             shifting;

  assign accept   = bus.par_valid && !hold_v_q;
  assign shifting = (state_q == SHIFT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = bus.par_in;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
          cnt_d  = cnt_q - 1'b1;
          if (accept) begin
            hold_d   = bus.par_in;
            hold_v_d = 1'b1;
          end
        end else if (hold_v_q) begin
          sreg_d   = hold_q;
          hold_v_d = 1'b0;
          cnt_d    = CNT_LAST;
        end else if (accept) begin
          // Hold is empty on the last bit: load straight from the bus.
          sreg_d = bus.par_in;
          cnt_d  = CNT_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.par_ready = !hold_v_q;
  assign bus.ser_valid = shifting;
  assign bus.ser_out   = shifting && (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);
  assign bus.ser_first = shifting && (cnt_q == CNT_LAST);
  assign bus.ser_last  = shifting && (cnt_q == '0);
  assign bus.busy      = shifting || hold_v_q;
endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench: an LSB-first and an MSB-first transmitter share one word
// stream; each serial output is reassembled into words and compared in order.
module tb_piso_shift_tx;
  logic clk;
  logic rst;

  piso_shift_if #(.WIDTH(8)) bus_l ();
  piso_shift_if #(.WIDTH(8)) bus_m ();

  piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));

  assign bus_m.par_in    = bus_l.par_in;
  assign bus_m.par_valid = bus_l.par_valid;

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_last_l = 0;
  int n_last_m = 0;
  int q_l[$];
  int q_m[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Call at a negedge; leaves the inputs applied across the next rising edge.
  task automatic step(input logic v, input logic [7:0] w, output logic acc);
    bus_l.par_valid = v;
    bus_l.par_in    = w;
    acc = v && bus_l.par_ready;
    if (acc) begin
      q_l.push_back(int'(w));
      q_m.push_back(int'(w));
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
  endtask

  task automatic send(input logic [7:0] w);
    logic a;
    int   k;
    a = 1'b0;
    k = 0;
    while (!a && k < 100) begin
      step(1'b1, w, a);
      k++;
    end
    if (!a) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (bus_l.busy && k < 200) begin
      idle(1);
      k++;
    end
    check("drain_busy", int'(bus_l.busy), 0);
  endtask

  // LSB-first monitor: bit i of the frame carries weight 2**i.
  int idx_l = 0;
  int w_l = 0;
  always @(negedge clk) begin
    if (!rst) begin
      idx_l = 0;
      w_l = 0;
    end else if (bus_l.ser_valid) begin
      check("first_l", int'(bus_l.ser_first), int'(idx_l == 0));
      check("last_l", int'(bus_l.ser_last), int'(idx_l == 7));
      w_l = w_l + (int'(bus_l.ser_out) << idx_l);
      if (idx_l == 7) begin
        n_last_l++;
        if (q_l.size() == 0) check("word_l_unexpected", w_l, -1);
        else check("word_l", w_l, q_l.pop_front());
        idx_l = 0;
        w_l = 0;
      end else begin
        idx_l++;
      end
    end else begin
      check("gap_l", idx_l, 0);
      check("idle_out_l", int'({bus_l.ser_out, bus_l.ser_first, bus_l.ser_last}), 0);
    end
  end

  // MSB-first monitor: each new bit doubles the accumulated value.
  int idx_m = 0;
  int w_m = 0;
  always @(negedge clk) begin
    if (!rst) begin
      idx_m = 0;
      w_m = 0;
    end else if (bus_m.ser_valid) begin
      check("first_m", int'(bus_m.ser_first), int'(idx_m == 0));
      check("last_m", int'(bus_m.ser_last), int'(idx_m == 7));
      w_m = w_m * 2 + int'(bus_m.ser_out);
      if (idx_m == 7) begin
        n_last_m++;
        if (q_m.size() == 0) check("word_m_unexpected", w_m, -1);
        else check("word_m", w_m, q_m.pop_front());
        idx_m = 0;
        w_m = 0;
      end else begin
        idx_m++;
      end
    end else begin
      check("gap_m", idx_m, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic pend_v;
    logic [7:0] pend_w;
    int run;
    int k;
    logic saw_nr;
    logic ready_ok;

    rst = 1'b0;
    bus_l.par_valid = 1'b0;
    bus_l.par_in = 8'h00;
    #1;
    check("rst_ready", int'(bus_l.par_ready), 1);
    check("rst_outs", int'({bus_l.ser_valid, bus_l.ser_out, bus_l.ser_first,
                            bus_l.ser_last, bus_l.busy}), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // Single word 0xA5: frame spans 8 cycles, idle again on the ninth.
    send(8'hA5);
    check("frame_busy", int'(bus_l.busy), 1);
    idle(8);
    check("cycle9_valid", int'(bus_l.ser_valid), 0);
    check("cycle9_busy", int'(bus_l.busy), 0);
    send(8'h80);
    drain();

    // Back-to-back 0x01, 0xFF, 0x3C with par_valid held: 24 contiguous bits.
    saw_nr = 1'b0;
    run = 0;
    fork
      begin
        send(8'h01);
        send(8'hFF);
        send(8'h3C);
        idle(1);
      end
      begin
        k = 0;
        while (!bus_l.ser_valid && k < 5) begin
          @(negedge clk);
          k++;
        end
        while (bus_l.ser_valid && run < 40) begin
          if (!bus_l.par_ready) saw_nr = 1'b1;
          run++;
          @(negedge clk);
        end
      end
    join
    check("b2b_run", run, 24);
    check("b2b_not_ready", int'(saw_nr), 1);
    drain();

    // Bypass: offer 0x5A exactly on the last bit of a frame with hold empty.
    send(8'h11);
    k = 0;
    while (!bus_l.ser_last && k < 20) begin
      idle(1);
      k++;
    end
    check("bypass_on_last", int'(bus_l.ser_last), 1);
    step(1'b1, 8'h5A, a);
    check("bypass_acc", int'(a), 1);
    check("bypass_start", int'({bus_l.ser_valid, bus_l.ser_first}), 3);
    ready_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!bus_l.par_ready) ready_ok = 1'b0;
      idle(1);
    end
    check("bypass_no_hold", int'(ready_ok), 1);
    drain();

    // Randomised stream, par_valid held until each word is taken.
    pend_v = 1'b0;
    pend_w = 8'h00;
    for (int i = 0; i < 400; i++) begin
      if (!pend_v) begin
        pend_v = ($urandom_range(0, 99) < 60);
        pend_w = 8'($urandom);
      end
      step(pend_v, pend_w, a);
      if (a) pend_v = 1'b0;
    end
    idle(1);
    drain();

    // Reset mid-frame with the holding buffer full.
    send(8'h33);
    send(8'h44);
    idle(2);
    check("pre_rst_hold_full", int'(bus_l.par_ready), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_outs", int'({bus_l.ser_valid, bus_l.ser_out, bus_l.busy}), 0);
    check("mid_rst_ready", int'(bus_l.par_ready), 1);
    @(negedge clk);
    n_acc = n_acc - q_l.size();
    q_l.delete();
    q_m.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("post_rst_quiet", int'(bus_l.ser_valid), 0);
      idle(1);
    end
    send(8'hC3);
    drain();

    check("accepts_vs_last_l", n_last_l, n_acc);
    check("accepts_vs_last_m", n_last_m, n_acc);
    check("queue_empty_l", q_l.size(), 0);
    check("queue_empty_m", q_m.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
